// File: rtl/ctrl_seq.sv
// Sequencing control unit: decodes opcode/func into a registered control bundle,
// runs the start/done program FSM and stalls fetch for MEM_LAT cycles on load/store.
// Optional perf counters (cyc_cnt/instr_cnt/stall_cnt) are enabled by CTRL_PERF_CNT_EN.
module ctrl_seq #(
    parameter int OPCODE_W = 3,
    parameter int FUNC_W   = 2,
    parameter int MEM_LAT  = 2,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func,
    output logic                pc_en,
    output logic                stall,
    output logic                busy,
    output logic                done,
    output logic                wr_en,
    output logic                carry_in,
    output logic                sub,
    output logic                alu_src,
    output logic                shift_left,
    output logic                branch_eq,
    output logic                use_dm,
    output logic                mem_read,
    output logic                sel_rs,
    output logic [1:0]          alu_op,
    output logic [1:0]          sel_rd
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    cyc_cnt,
    output logic [CNT_W-1:0]    instr_cnt,
    output logic [CNT_W-1:0]    stall_cnt
`endif
);

    if (OPCODE_W < 3 || FUNC_W < 2 || MEM_LAT < 1 || MEM_LAT > 15 || CNT_W < 1) begin : g_param_check
        $error("ctrl_seq: parameter out of range");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_MEM  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef struct packed {
        logic       wr_en;
        logic       carry_in;
        logic       sub;
        logic       alu_src;
        logic       shift_left;
        logic       branch_eq;
        logic       use_dm;
        logic       mem_read;
        logic       sel_rs;
        logic [1:0] alu_op;
        logic [1:0] sel_rd;
    } ctrl_t;

    logic [1:0] state;
    logic [3:0] mem_cnt;
    ctrl_t      bundle_q;
    ctrl_t      dec;
    logic       is_mem;
    logic       is_halt;
    logic       op_hi;
    logic       accept;

    assign op_hi  = |(opcode >> 3);
    assign stall  = (state == S_MEM);
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign accept = (state == S_RUN) && instr_valid;
    assign pc_en  = accept && !stall;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        dec     = '0;
        is_mem  = 1'b0;
        is_halt = 1'b0;
        if (!op_hi) begin
            unique case (opcode[2:0])
                3'b000: begin dec.wr_en = 1'b1; dec.carry_in = func[0]; end
                3'b001: begin dec.wr_en = 1'b1; dec.sub = 1'b1; dec.carry_in = 1'b1; end
                3'b010: begin dec.wr_en = 1'b1; dec.alu_op = 2'b01; end
                3'b011: begin
                    dec.wr_en = 1'b1; dec.alu_src = 1'b1; dec.sel_rs = 1'b1; dec.sel_rd = 2'b10;
                end
                3'b100: begin dec.wr_en = 1'b1; dec.alu_op = 2'b10; dec.shift_left = func[0]; end
                3'b101: begin
                    dec.wr_en = 1'b1; dec.use_dm = 1'b1; dec.mem_read = 1'b1; dec.sel_rd = 2'b01;
                    is_mem = 1'b1;
                end
                3'b110: begin dec.use_dm = 1'b1; dec.alu_op = 2'b11; is_mem = 1'b1; end
                3'b111: begin
                    if (&func) is_halt = 1'b1;
                    else begin dec.sub = 1'b1; dec.branch_eq = func[0]; end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            mem_cnt  <= 4'd0;
            bundle_q <= '0;
        end else begin
            // Bundle is a NOP unless an instruction is accepted this cycle.
            bundle_q <= '0;
            case (state)
                S_IDLE: if (start) state <= S_RUN;
                S_RUN: begin
                    if (accept) begin
                        if (is_halt) begin
                            state <= S_DONE;
                        end else begin
                            bundle_q <= dec;
                            if (is_mem) begin
                                state   <= S_MEM;
                                mem_cnt <= 4'(MEM_LAT - 1);
                            end
                        end
                    end
                end
                S_MEM: begin
                    if (mem_cnt == 4'd0) state <= S_RUN;
                    else mem_cnt <= mem_cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wr_en      = bundle_q.wr_en;
    assign carry_in   = bundle_q.carry_in;
    assign sub        = bundle_q.sub;
    assign alu_src    = bundle_q.alu_src;
    assign shift_left = bundle_q.shift_left;
    assign branch_eq  = bundle_q.branch_eq;
    assign use_dm     = bundle_q.use_dm;
    assign mem_read   = bundle_q.mem_read;
    assign sel_rs     = bundle_q.sel_rs;
    assign alu_op     = bundle_q.alu_op;
    assign sel_rd     = bundle_q.sel_rd;

`ifdef CTRL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Counters only advance while busy, so they hold their final values once back in IDLE.
    always_ff @(posedge clk) begin
        if (reset || (state == S_IDLE && start)) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (busy && cyc_cnt != CNT_MAX)     cyc_cnt   <= cyc_cnt + 1'b1;
            if (accept && instr_cnt != CNT_MAX) instr_cnt <= instr_cnt + 1'b1;
            if (stall && stall_cnt != CNT_MAX)  stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed testbench for ctrl_seq (MEM_LAT=3 main instance, MEM_LAT=1 side instance).
// Perf-counter checks are compiled in when CTRL_PERF_CNT_EN is defined.
module tb_ctrl_seq;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       reset, start, instr_valid;
    logic [2:0] opcode;
    logic [1:0] func;

    logic pc_en, stall, busy, done;
    logic wr_en, carry_in, sub, alu_src, shift_left, branch_eq, use_dm, mem_read, sel_rs;
    logic [1:0] alu_op, sel_rd;

    logic pc_en1, stall1, busy1, done1;
    logic wr_en1, carry_in1, sub1, alu_src1, shift_left1, branch_eq1, use_dm1, mem_read1, sel_rs1;
    logic [1:0] alu_op1, sel_rd1;

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] cyc_cnt, instr_cnt, stall_cnt;
    logic [15:0] cyc_cnt1, instr_cnt1, stall_cnt1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ctrl_seq #(.OPCODE_W(3), .FUNC_W(2), .MEM_LAT(LAT), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .instr_valid(instr_valid),
        .opcode(opcode), .func(func),
        .pc_en(pc_en), .stall(stall), .busy(busy), .done(done),
        .wr_en(wr_en), .carry_in(carry_in), .sub(sub), .alu_src(alu_src),
        .shift_left(shift_left), .branch_eq(branch_eq), .use_dm(use_dm),
        .mem_read(mem_read), .sel_rs(sel_rs), .alu_op(alu_op), .sel_rd(sel_rd)
`ifdef CTRL_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
    );

    ctrl_seq #(.OPCODE_W(3), .FUNC_W(2), .MEM_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .reset(reset), .start(start), .instr_valid(instr_valid),
        .opcode(opcode), .func(func),
        .pc_en(pc_en1), .stall(stall1), .busy(busy1), .done(done1),
        .wr_en(wr_en1), .carry_in(carry_in1), .sub(sub1), .alu_src(alu_src1),
        .shift_left(shift_left1), .branch_eq(branch_eq1), .use_dm(use_dm1),
        .mem_read(mem_read1), .sel_rs(sel_rs1), .alu_op(alu_op1), .sel_rd(sel_rd1)
`ifdef CTRL_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt1), .instr_cnt(instr_cnt1), .stall_cnt(stall_cnt1)
`endif
    );

    logic [12:0] obs_b;
    logic [3:0]  obs_s;
    assign obs_b = {wr_en, carry_in, sub, alu_src, shift_left, branch_eq,
                    use_dm, mem_read, sel_rs, alu_op, sel_rd};
    assign obs_s = {pc_en, stall, busy, done};

    // Expected bundle from named fields, same bit order as obs_b.
    function automatic logic [12:0] bnd(input logic wr, ci, sb, as, sl, beq, udm, mr, srs,
                                        input logic [1:0] aop, srd);
        return {wr, ci, sb, as, sl, beq, udm, mr, srs, aop, srd};
    endfunction

    localparam logic [12:0] B_NOP = 13'd0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; instr_valid = 1'b0; opcode = 3'd0; func = 2'd0;
        cyc(); cyc();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            chk("idle_status", 32'(obs_s), 32'(4'b0000));
            chk("idle_bundle", 32'(obs_b), 32'(B_NOP));
        end

        // Start, then add with func=01
        start = 1'b1;
        cyc();
        start = 1'b0; instr_valid = 1'b1; opcode = 3'b000; func = 2'b01;
        #1;
        chk("add_pc_en", 32'(obs_s), 32'(4'b1010));
        chk("add_pre_bundle", 32'(obs_b), 32'(B_NOP));
        cyc();
        instr_valid = 1'b0; start = 1'b1;
        #1;
        chk("add_bundle", 32'(obs_b), 32'(bnd(1,1,0,0,0,0,0,0,0,2'b00,2'b00)));
        chk("add_status", 32'(obs_s), 32'(4'b0010));

        // start during RUN is ignored; load follows
        cyc();
        start = 1'b0; instr_valid = 1'b1; opcode = 3'b101; func = 2'b00;
        #1;
        chk("start_in_run_ignored", 32'(obs_s), 32'(4'b1010));
        chk("nop_bundle", 32'(obs_b), 32'(B_NOP));
        cyc();
        opcode = 3'b010;
        #1;
        chk("load_stall1", 32'(obs_s), 32'(4'b0110));
        chk("load_bundle", 32'(obs_b), 32'(bnd(1,0,0,0,0,0,1,1,0,2'b00,2'b01)));
        chk("lat1_stall1", 32'(stall1), 32'(1'b1));
        cyc(); #1;
        chk("load_stall2", 32'(obs_s), 32'(4'b0110));
        chk("load_mem_nop", 32'(obs_b), 32'(B_NOP));
        chk("lat1_stall_end", 32'(stall1), 32'(1'b0));
        cyc(); #1;
        chk("load_stall3", 32'(obs_s), 32'(4'b0110));
        chk("load_mem_nop2", 32'(obs_b), 32'(B_NOP));
        cyc(); #1;
        chk("load_back_run", 32'(obs_s), 32'(4'b1010));

        // and, branch, shift, addi, sub
        cyc();
        opcode = 3'b111; func = 2'b01;
        #1;
        chk("and_bundle", 32'(obs_b), 32'(bnd(1,0,0,0,0,0,0,0,0,2'b01,2'b00)));
        cyc();
        opcode = 3'b100; func = 2'b01;
        #1;
        chk("branch_bundle", 32'(obs_b), 32'(bnd(0,0,1,0,0,1,0,0,0,2'b00,2'b00)));
        cyc();
        opcode = 3'b011; func = 2'b00;
        #1;
        chk("shift_bundle", 32'(obs_b), 32'(bnd(1,0,0,0,1,0,0,0,0,2'b10,2'b00)));
        cyc();
        opcode = 3'b001; func = 2'b00;
        #1;
        chk("addi_bundle", 32'(obs_b), 32'(bnd(1,0,0,1,0,0,0,0,1,2'b00,2'b10)));
        cyc();
        opcode = 3'b110; func = 2'b00;
        #1;
        chk("sub_bundle", 32'(obs_b), 32'(bnd(1,1,1,0,0,0,0,0,0,2'b00,2'b00)));

        // store enters MEM
        cyc();
        instr_valid = 1'b0;
        #1;
        chk("store_bundle", 32'(obs_b), 32'(bnd(0,0,0,0,0,0,1,0,0,2'b11,2'b00)));
        chk("store_stall", 32'(obs_s), 32'(4'b0110));
        cyc(); cyc(); cyc(); #1;
        chk("store_back_run", 32'(obs_s), 32'(4'b0010));

        // halt -> DONE one cycle -> IDLE
        instr_valid = 1'b1; opcode = 3'b111; func = 2'b11;
        cyc();
        instr_valid = 1'b0;
        #1;
        chk("halt_done", 32'(obs_s), 32'(4'b0011));
        chk("halt_no_bundle", 32'(obs_b), 32'(B_NOP));
        cyc(); #1;
        chk("after_done_idle", 32'(obs_s), 32'(4'b0000));
        cyc(); #1;
        chk("done_single_pulse", 32'(obs_s), 32'(4'b0000));

        // reset during MEM aborts the op
        start = 1'b1;
        cyc();
        start = 1'b0; instr_valid = 1'b1; opcode = 3'b101; func = 2'b00;
        cyc();
        instr_valid = 1'b0;
        #1;
        chk("pre_reset_stall", 32'(obs_s), 32'(4'b0110));
        reset = 1'b1;
        cyc(); #1;
        chk("reset_mid_mem", 32'(obs_s), 32'(4'b0000));
        chk("reset_mid_mem_bundle", 32'(obs_b), 32'(B_NOP));
        start = 1'b1;
        cyc(); #1;
        chk("reset_beats_start", 32'(obs_s), 32'(4'b0000));
        reset = 1'b0; start = 1'b0;
        cyc();

`ifdef CTRL_PERF_CNT_EN
        // add, load, halt
        start = 1'b1;
        cyc();
        start = 1'b0; instr_valid = 1'b1; opcode = 3'b000; func = 2'b00;
        cyc();
        opcode = 3'b101;
        cyc();
        instr_valid = 1'b0;
        for (int i = 0; i < LAT; i++) cyc();
        instr_valid = 1'b1; opcode = 3'b111; func = 2'b11;
        cyc();
        instr_valid = 1'b0;
        cyc(); cyc(); #1;
        chk("perf_instr", 32'(instr_cnt), 32'd3);
        chk("perf_stall", 32'(stall_cnt), 32'(LAT));
        chk("perf_cyc", 32'(cyc_cnt), 32'(4 + LAT));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
